// File: rtl/arg_serializer.sv
// Serialises one signed argument as ASCII: title letter, optional '-', decimal magnitude.
// Optional trailing space after the last digit when ARG_SERIALIZER_SPACE_EN is defined.
module arg_serializer #(
  parameter int NUM_BITS = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clk_en,
  input  logic                       trigger,
  input  logic [7:0]                 arg_title,
  input  logic signed [NUM_BITS-1:0] num,
  input  logic                       is_full,
  input  logic                       wr_done,
  output logic [7:0]                 char_out,
  output logic                       wr_trigger,
  output logic                       rdy,
  output logic                       done
);

  localparam int ND = (3 * NUM_BITS + 9) / 10;
  localparam int BW = 4 * ND;
  localparam int CW = $clog2(NUM_BITS + 1);
  localparam int DW = $clog2(ND);

  typedef enum logic [2:0] {IDLE, CONVERT, EMIT, WAIT_WR, FINISH} state_t;
  typedef enum logic [1:0] {SEL_TITLE, SEL_SIGN, SEL_DIGIT, SEL_SPACE} sel_t;

  state_t              state_q, state_d;
  sel_t                sel_q, sel_d;
  logic [7:0]          title_q, title_d;
  logic                neg_q, neg_d;
  logic [NUM_BITS-1:0] mag_q, mag_d;
  logic [BW-1:0]       bcd_q, bcd_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DW-1:0]       msd_q, msd_d;
  logic [DW-1:0]       dig_q, dig_d;
  logic [7:0]          char_q, char_d;
  logic                wrt_q, wrt_d;
  logic [7:0]          cur_char;

  function automatic logic [BW-1:0] dabble_step(input logic [BW-1:0] b, input logic in_bit);
    logic [BW-1:0] a;
    a = b;
    for (int i = 0; i < ND; i++) begin
      if (a[4*i +: 4] >= 4'd5) a[4*i +: 4] = a[4*i +: 4] + 4'd3;
    end
    return {a[BW-2:0], in_bit};
  endfunction

  // Highest non-zero digit; an all-zero value resolves to digit 0 so '0' is still printed.
  function automatic logic [DW-1:0] msd_index(input logic [BW-1:0] b);
    logic [DW-1:0] m;
    m = '0;
    for (int i = 0; i < ND; i++) begin
      if (b[4*i +: 4] != 4'd0) m = DW'(i);
    end
    return m;
  endfunction

  always_comb begin
    cur_char = title_q;
    case (sel_q)
      SEL_TITLE: cur_char = title_q;
      SEL_SIGN:  cur_char = 8'h2D;
      SEL_DIGIT: cur_char = {4'h3, bcd_q[4*dig_q +: 4]};
      SEL_SPACE: cur_char = 8'h20;
      default:   cur_char = title_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    title_d = title_q;
    neg_d   = neg_q;
    mag_d   = mag_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    msd_d   = msd_q;
    dig_d   = dig_q;
    char_d  = char_q;
    wrt_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (trigger) begin
          title_d = arg_title;
          neg_d   = num[NUM_BITS-1];
          mag_d   = num[NUM_BITS-1] ? -num : num;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        bcd_d = dabble_step(bcd_q, mag_q[NUM_BITS-1]);
        mag_d = {mag_q[NUM_BITS-2:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(NUM_BITS - 1)) begin
          msd_d   = msd_index(bcd_d);
          sel_d   = SEL_TITLE;
          dig_d   = '0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        // Request is registered so char_out and wr_trigger rise together.
        if (!is_full) begin
          wrt_d   = 1'b1;
          char_d  = cur_char;
          state_d = WAIT_WR;
        end
      end
      WAIT_WR: begin
        if (wr_done) begin
          state_d = EMIT;
          case (sel_q)
            SEL_TITLE: begin
              sel_d = neg_q ? SEL_SIGN : SEL_DIGIT;
              dig_d = msd_q;
            end
            SEL_SIGN: begin
              sel_d = SEL_DIGIT;
              dig_d = msd_q;
            end
            SEL_DIGIT: begin
              if (dig_q == '0) begin
`ifdef ARG_SERIALIZER_SPACE_EN
                sel_d = SEL_SPACE;
`else
                state_d = FINISH;
`endif
              end else begin
                dig_d = dig_q - 1'b1;
              end
            end
            default: state_d = FINISH;
          endcase
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= SEL_TITLE;
      title_q <= '0;
      neg_q   <= 1'b0;
      mag_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      msd_q   <= '0;
      dig_q   <= '0;
      char_q  <= '0;
      wrt_q   <= 1'b0;
    end else if (clk_en) begin
      state_q <= state_d;
      sel_q   <= sel_d;
      title_q <= title_d;
      neg_q   <= neg_d;
      mag_q   <= mag_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      msd_q   <= msd_d;
      dig_q   <= dig_d;
      char_q  <= char_d;
      wrt_q   <= wrt_d;
    end
  end

  assign char_out   = char_q;
  assign wr_trigger = wrt_q & clk_en;
  assign done       = (state_q == FINISH) & clk_en;
  assign rdy        = (state_q == IDLE);

endmodule

// File: tb/tb_arg_serializer.sv
// Bench for arg_serializer: fixed vectors, corner-case sequences and random arguments
// checked against a string-formatting reference model.
module tb_arg_serializer;

  localparam int NB = 16;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 clk_en;
  logic                 trigger;
  logic [7:0]           arg_title;
  logic signed [NB-1:0] num;
  logic                 is_full;
  logic                 wr_done;
  logic [7:0]           char_out;
  logic                 wr_trigger;
  logic                 rdy;
  logic                 done;

  arg_serializer #(.NUM_BITS(NB)) dut (
    .clk        (clk),
    .reset      (reset),
    .clk_en     (clk_en),
    .trigger    (trigger),
    .arg_title  (arg_title),
    .num        (num),
    .is_full    (is_full),
    .wr_done    (wr_done),
    .char_out   (char_out),
    .wr_trigger (wr_trigger),
    .rdy        (rdy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  title;
    logic [15:0] num;
    logic [3:0]  len;
    logic [63:0] exp;
  } vec_t;

  vec_t       vecs[7];
  int         total = 0;
  int         bad = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int         lat, done_cnt, timed_out;
  logic       stable_ok, full_ok, rdy_after, busy_rdy;

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic model_expect(input logic [7:0] t, input logic [NB-1:0] n);
    longint v;
    string  s;
    exp_q.delete();
    exp_q.push_back(t);
    v = longint'($signed(n));
    if (v < 0) begin
      exp_q.push_back(8'h2D);
      v = -v;
    end
    s = $sformatf("%0d", v);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
`ifdef ARG_SERIALIZER_SPACE_EN
    exp_q.push_back(8'h20);
`endif
  endtask

  task automatic table_expect(input vec_t v);
    exp_q.delete();
    for (int i = 0; i < int'(v.len); i++) exp_q.push_back(v.exp[63-8*i -: 8]);
`ifdef ARG_SERIALIZER_SPACE_EN
    exp_q.push_back(8'h20);
`endif
  endtask

  // mode 0 plain, 1 is_full hold before 3rd char, 2 trigger noise mid-stream,
  // 3 random clk_en, 4 stop right after the 2nd write request
  task automatic run_stream(input logic [7:0] t, input logic [NB-1:0] n, input int mode);
    int         en_cyc, wcnt, ntrig, full_left;
    logic       pend, seen_done;
    logic [7:0] cur, hold_char;
    got_q.delete();
    en_cyc = 0; wcnt = 0; ntrig = 0; full_left = 0;
    pend = 1'b0; seen_done = 1'b0; cur = 8'h00; hold_char = 8'h00;
    lat = -1; done_cnt = 0; stable_ok = 1'b1; full_ok = 1'b1; rdy_after = 1'b0; busy_rdy = 1'b1;
    timed_out = 1;
    @(negedge clk);
    arg_title = t; num = n; trigger = 1'b1; clk_en = 1'b1; is_full = 1'b0; wr_done = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (seen_done) begin
        rdy_after = rdy;
        timed_out = 0;
        break;
      end
      clk_en  = (mode == 3) ? 1'($urandom_range(0, 1)) : 1'b1;
      trigger = (mode == 2 && ntrig >= 1 && ntrig <= 2);
      if (trigger) begin
        num = ~n;
        arg_title = 8'h51;
      end
      if (wcnt > 0) wcnt--;
      wr_done = pend && (wcnt == 0);
      is_full = (full_left > 0);
      if (clk_en) en_cyc++;
      #1;
      if (wr_trigger && is_full) full_ok = 1'b0;
      if (is_full && char_out != hold_char) full_ok = 1'b0;
      if (wr_trigger) begin
        if (pend) stable_ok = 1'b0;
        got_q.push_back(char_out);
        ntrig++;
        cur = char_out; pend = 1'b1; wcnt = 2;
        if (lat < 0) begin
          lat = en_cyc;
          busy_rdy = rdy;
        end
        if (mode == 4 && ntrig == 2) begin
          timed_out = 0;
          break;
        end
      end else if (pend && char_out != cur) begin
        stable_ok = 1'b0;
      end
      if (done) begin
        done_cnt++;
        seen_done = 1'b1;
      end
      if (is_full) full_left--;
      if (wr_done && clk_en) begin
        pend = 1'b0;
        if (mode == 1 && ntrig == 2) begin
          full_left = 20;
          hold_char = cur;
        end
      end
    end
    trigger = 1'b0; wr_done = 1'b0; is_full = 1'b0; clk_en = 1'b1;
  endtask

  task automatic post_checks(input string name, input int mode);
    check({name, "_timeout"}, timed_out, 0);
    check({name, "_latency"}, lat, NB + 2);
    check({name, "_rdy_busy"}, busy_rdy, 0);
    check({name, "_stable"}, stable_ok, 1);
    if (mode != 4) begin
      check({name, "_done_cnt"}, done_cnt, 1);
      check({name, "_rdy_after"}, rdy_after, 1);
      check({name, "_len"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
        check($sformatf("%s_c%0d", name, i), got_q[i], exp_q[i]);
    end
    if (mode == 1) check({name, "_full_hold"}, full_ok, 1);
  endtask

  initial begin
    int       stray;
    int       mode;
    logic [7:0]    t;
    logic [NB-1:0] n;

    vecs[0] = '{8'h58, 16'd123,  4'd4, 64'h5831323300000000};
    vecs[1] = '{8'h59, 16'hFFD3, 4'd4, 64'h592D343500000000};
    vecs[2] = '{8'h5A, 16'd0,    4'd2, 64'h5A30000000000000};
    vecs[3] = '{8'h58, 16'h8000, 4'd7, 64'h582D333237363800};
    vecs[4] = '{8'h58, 16'h7FFF, 4'd6, 64'h5833323736370000};
    vecs[5] = '{8'h42, 16'hFFFF, 4'd3, 64'h422D310000000000};
    vecs[6] = '{8'h41, 16'd7,    4'd2, 64'h4137000000000000};

    reset = 1'b1; clk_en = 1'b1; trigger = 1'b0; arg_title = 8'h00; num = '0;
    is_full = 1'b0; wr_done = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_rdy", rdy, 1);
    check("reset_wr_trigger", wr_trigger, 0);
    check("reset_done", done, 0);
    check("reset_char_out", char_out, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_stream(vecs[i].title, vecs[i].num, 0);
      table_expect(vecs[i]);
      post_checks($sformatf("vec%0d", i), 0);
    end

    run_stream(8'h58, 16'h8000, 1);
    table_expect(vecs[3]);
    post_checks("full_hold", 1);

    run_stream(8'h58, 16'd123, 2);
    table_expect(vecs[0]);
    post_checks("trig_ignored", 2);

    run_stream(8'h58, 16'h8000, 3);
    table_expect(vecs[3]);
    post_checks("clk_en_half", 3);

    run_stream(8'h58, 16'd123, 4);
    post_checks("abort_pre", 4);
    check("abort_got2", got_q.size(), 2);
    @(negedge clk);
    wr_done = 1'b0;
    reset = 1'b1;
    #1;
    check("abort_rdy", rdy, 1);
    check("abort_wr_trigger", wr_trigger, 0);
    check("abort_done", done, 0);
    check("abort_char_out", char_out, 0);
    @(negedge clk);
    reset = 1'b0;
    stray = 0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (wr_trigger || done) stray++;
    end
    check("abort_no_wr", stray, 0);
    run_stream(8'h58, 16'd123, 0);
    model_expect(8'h58, 16'd123);
    post_checks("after_abort", 0);

    for (int i = 0; i < 16; i++) begin
      t = 8'h41 + 8'($urandom_range(0, 25));
      case (i)
        0:       n = 16'h8000;
        1:       n = 16'h7FFF;
        2:       n = 16'd0;
        default: n = NB'($urandom);
      endcase
      mode = (i < 3) ? 0 : int'($urandom_range(0, 3));
      run_stream(t, n, mode);
      model_expect(t, n);
      post_checks($sformatf("rnd%0d_m%0d", i, mode), mode);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
